// File: rtl/cook_timer_if.sv
// Keypad, magnetron-latch and display signals for cook_timer.
// The master drives the keypad and latch state. The slave (cook_timer) drives the display, status and debug state.
interface cook_timer_if;
  // digit_valid is a single-cycle strobe with no ready back-pressure.
  // The digit is taken in the same cycle if the timer state and the value allow it, and is dropped otherwise.
  logic       digit_valid;
  logic [3:0] digit;
  logic       mag_on;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;
  logic       running;
  logic       beep;
  logic [2:0] state_dbg;

  modport master (
    output digit_valid, digit, mag_on,
    input  min_tens, min_ones, sec_tens, sec_ones, timer_done, running, beep, state_dbg
  );

  modport slave (
    input  digit_valid, digit, mag_on,
    output min_tens, min_ones, sec_tens, sec_ones, timer_done, running, beep, state_dbg
  );
endinterface

// File: rtl/cook_timer.sv
// MM:SS BCD cook timer. It counts down at one tick per CLK_DIV clocks while mag_on is high, and drives timer_done.
// Defining the macro END_BEEP_EN builds a BEEP_LEN-cycle end-of-cook beep. Otherwise beep is tied low.
module cook_timer #(
  parameter int CLK_DIV  = 50000000,
  parameter int BEEP_LEN = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clearn,
  cook_timer_if.slave  bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [15:0]   tval, tval_n;
  logic [PW-1:0] presc, presc_n;
  logic          timer_done_q, running_q;
  logic          accept, tick;
  logic [15:0]   shifted, decremented;

  // Borrowing BCD decrement. Seconds above 59 count down as-is, and 00:00 stays 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else if (t[11:8] != 4'd0) begin
      r[11:8] = t[11:8] - 4'd1;
      r[7:4]  = 4'd5;
      r[3:0]  = 4'd9;
    end else if (t[15:12] != 4'd0) begin
      r[15:12] = t[15:12] - 4'd1;
      r[11:8]  = 4'd9;
      r[7:4]   = 4'd5;
      r[3:0]   = 4'd9;
    end
    return r;
  endfunction

  assign accept      = bus.digit_valid && (bus.digit <= 4'd9) &&
                       ((state == IDLE) || (state == SET) || (state == DONE));
  assign shifted     = {tval[11:0], bus.digit};
  assign decremented = bcd_dec(tval);
  assign tick        = (presc == PW'(CLK_DIV - 1));

  always_comb begin
    state_n = state;
    tval_n  = tval;
    presc_n = presc;
    if (!clearn) begin
      state_n = IDLE;
      tval_n  = 16'h0000;
      presc_n = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            tval_n  = shifted;
            state_n = (shifted == 16'h0000) ? IDLE : SET;
          end
        end
        SET: begin
          if (accept) begin
            tval_n  = shifted;
            state_n = (shifted == 16'h0000) ? IDLE : SET;
          end else if (bus.mag_on) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        RUN: begin
          // Losing mag_on wins over a coincident tick, so that second is not consumed.
          if (!bus.mag_on) begin
            state_n = PAUSE;
          end else if (tick) begin
            presc_n = '0;
            tval_n  = decremented;
            if (decremented == 16'h0000) state_n = DONE;
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        PAUSE: begin
          if (bus.mag_on) state_n = RUN;
        end
        default: begin
          state_n = IDLE;
          tval_n  = 16'h0000;
          presc_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      tval         <= 16'h0000;
      presc        <= '0;
      timer_done_q <= 1'b1;
      running_q    <= 1'b0;
    end else begin
      state        <= state_n;
      tval         <= tval_n;
      presc        <= presc_n;
      timer_done_q <= (state_n == IDLE) || (state_n == DONE);
      running_q    <= (state_n == RUN);
    end
  end

`ifdef END_BEEP_EN
  localparam int BW = $clog2(BEEP_LEN + 1);
  logic [BW-1:0] beep_cnt;
  logic          done_evt;

  assign done_evt = (state == RUN) && (state_n == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beep_cnt <= '0;
    end else if (!clearn || accept) begin
      beep_cnt <= '0;
    end else if (done_evt) begin
      beep_cnt <= BW'(BEEP_LEN);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - BW'(1);
    end
  end

  assign bus.beep = (beep_cnt != '0);
`else
  assign bus.beep = 1'b0;
`endif

  assign bus.min_tens   = tval[15:12];
  assign bus.min_ones   = tval[11:8];
  assign bus.sec_tens   = tval[7:4];
  assign bus.sec_ones   = tval[3:0];
  assign bus.timer_done = timer_done_q;
  assign bus.running    = running_q;
  assign bus.state_dbg  = state;

endmodule
